button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
Front-end controller for the panel's push-buttons. It generates a configurable sample tick, runs one tick-gated 8-sample debouncer per button, and detects press and release edges. Edges are arbitrated round-robin into a small event FIFO, which downstream logic (e.g. the RGB channel-select/increment logic) drains over a valid/ready handshake.

Parameters:
NUM_BTN, 4, number of button inputs (2..8)
TICK_DIV, 1000, clk cycles per debounce sample tick (>=2)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = tick counter runs; 0 = sampling frozen
buttons  input  NUM_BTN  raw, already-synchronised button levels
db_state  output  NUM_BTN  debounced levels, registered
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts head this cycle
evt_id  output  clog2(NUM_BTN)  button index of head event
evt_press  output  1  1 = press (0->1), 0 = release (1->0)
overflow  output  1  sticky: an edge was overwritten before it was queued
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (reset=1 at posedge):
  - tick counter=0, all shift registers=0, db_state=0, db_prev=0.
  - pending=0, FIFO empty, evt_valid=0, evt_id=0, evt_press=0, overflow=0.
  - last_grant=NUM_BTN-1, so button 0 has first priority.
  - Reset mid-operation discards all queued events. No release event is generated for buttons that were high.
- Tick:
  - Counter increments while enable=1. tick=1 for one cycle when the counter reaches TICK_DIV-1, then the counter wraps to 0.
  - enable=0 holds the counter value and produces no ticks.
- Debounce (per button, on tick only):
  - sreg <= {sreg[6:0], button}.
  - db_state goes to 1 when the updated sreg is all ones, and to 0 when it is all zeros; otherwise it holds.
  - A steady input is therefore reflected on the clock edge of the 8th consecutive tick.
- Edge detect:
  - db_prev <= db_state every cycle; edge[i] = db_state[i] ^ db_prev[i].
  - On edge[i]: pending[i] <= 1 and pend_dir[i] <= db_state[i].
  - If pending[i] is already set and not granted this cycle, pend_dir is overwritten and overflow <= 1.
- Arbiter:
  - Runs each cycle when the FIFO is not full, where full is evaluated before this cycle's pop.
  - Grants the first pending button searching from last_grant+1, wrapping modulo NUM_BTN.
  - A grant pushes {id, dir}, clears pending[grant] and updates last_grant. At most one push per cycle.
  - A new edge on the granted button in the same cycle sets pending again (set wins over clear) and does not flag overflow.
- Latency: db_state change at edge E0 -> pending at E1 -> pushed at E2 -> evt_valid=1 after E2, if the FIFO is not full.
- FIFO:
  - Head is registered; evt_* reflect the head while evt_valid=1.
  - Pop on evt_valid & evt_ready. Push and pop may occur in the same cycle unless full.
  - When full, no push: pending bits wait and nothing is lost unless the same button edges again.
  - Pointers wrap modulo FIFO_DEPTH using an extra MSB for the full/empty distinction.
- Overflow: clear_overflow clears it; a simultaneous set wins.
- enable=0: no new debounced edges occur; pending bits and the FIFO continue to drain normally.

Decomposition:
- Package btn_evt_pkg:
  - BTN_ID_W = clog2(NUM_BTN_MAX=8) helper function.
  - EVT_PRESS=1'b1 and EVT_RELEASE=1'b0 constants.
  - Event word layout {id, dir}, EVT_W = BTN_ID_W+1.
- Sub-module debounce_tick, one instance per button: clk, reset, tick, button in; debounced out (8-sample shift register gated by tick).
- Tick divider, edge detect, round-robin arbiter and FIFO live in the top.

Test Plan:
- Single press. Setup: TICK_DIV=4, buttons[2] 0->1 held. Required: db_state[2]=1 at the 8th tick edge; 2 cycles later evt_valid=1, evt_id=2, evt_press=1. After release held, an event {2,0} follows.
- Bounce rejection. Stimulus: buttons[1] toggled every 3 ticks for 40 ticks. Required: db_state[1] stays 0, evt_valid never asserts, overflow=0.
- Round-robin. With last_grant=1, buttons 0 and 3 debounce high on the same tick and evt_ready=1. Required: events {3,1} then {0,1} on consecutive cycles.
- Backpressure. Setup: FIFO_DEPTH=4, evt_ready=0, presses on 0,1,2,3 then 0 released. Required: FIFO holds 4 events and pending[0] waits. After evt_ready=1, 5 events arrive in order with none lost and overflow=0.
- Overflow. Setup: evt_ready=0, FIFO full, button 1 pressed then released (both debounced). Required: overflow=1 and the single queued event for button 1 is a release. After clear_overflow, overflow=0.
- Reset and enable. Reset with 3 queued events and db_state=4'b0101: evt_valid=0 the next cycle, db_state=0, no release events afterwards. With enable=0, a steady press never sets db_state.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared widths, event direction constants and event-word helper
// for the push-button event front-end.
// No ports (package).
package btn_evt_pkg;

    localparam int NUM_BTN_MAX = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BTN_ID_W = id_width(NUM_BTN_MAX);
    localparam int EVT_W    = BTN_ID_W + 1;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    // Event word layout: {id, dir}
    typedef logic [EVT_W-1:0] evt_word_t;

    function automatic evt_word_t pack_evt(input logic [BTN_ID_W-1:0] id, input logic dir);
        return {id, dir};
    endfunction

endpackage

// File: rtl/debounce_tick.sv
// debounce_tick: 8-sample tick-gated debouncer for one button.
// Ports: clk, reset (sync, active-high), tick (sample strobe), button (raw level),
//        debounced (registered debounced level).
module debounce_tick (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic button,
    output logic debounced
);

    logic [7:0] sreg;
    logic [7:0] sreg_next;

    assign sreg_next = {sreg[6:0], button};

    // The level only changes once eight consecutive samples agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg      <= '0;
            debounced <= 1'b0;
        end else if (tick) begin
            sreg <= sreg_next;
            if (&sreg_next)
                debounced <= 1'b1;
            else if (~|sreg_next)
                debounced <= 1'b0;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces push-buttons, detects press/release edges and
// queues them round-robin into an event FIFO drained by valid/ready.
// Ports: clk, reset (sync, active-high), enable (sample tick runs), buttons (raw),
//        db_state (debounced levels), evt_valid/evt_ready/evt_id/evt_press (event
//        stream), overflow (sticky lost-edge flag), clear_overflow.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int TICK_DIV   = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_BTN-1:0]         buttons,
    output logic [NUM_BTN-1:0]         db_state,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic                       evt_press,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int ID_W  = $clog2(NUM_BTN);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = ID_W + 1;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [NUM_BTN-1:0] db_prev;
    logic [NUM_BTN-1:0] edges;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] pend_dir;
    logic [NUM_BTN-1:0] gmask;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant;
    logic               grant_valid;
    logic               ovf_set;
    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic               full;
    logic               pop;
    logic [EW-1:0]      head;

    assign tick = enable && (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        debounce_tick u_db (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .button    (buttons[i]),
            .debounced (db_state[i])
        );
    end

    assign edges = db_state ^ db_prev;

    // Full is taken from the registered pointers, i.e. before this cycle's pop.
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign evt_valid = wptr != rptr;
    assign pop       = evt_valid && evt_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (!full) begin
            for (int k = 1; k <= NUM_BTN; k++) begin
                if (!grant_valid && pending[(int'(last_grant) + k) % NUM_BTN]) begin
                    grant_valid = 1'b1;
                    grant       = ID_W'((int'(last_grant) + k) % NUM_BTN);
                end
            end
        end
    end

    assign gmask   = NUM_BTN'(grant_valid) << grant;
    // A re-edge on the button being granted this cycle is simply re-queued.
    assign ovf_set = |(edges & pending & ~gmask);

    always_ff @(posedge clk) begin
        if (reset) begin
            db_prev    <= '0;
            pending    <= '0;
            pend_dir   <= '0;
            last_grant <= ID_W'(NUM_BTN - 1);
            overflow   <= 1'b0;
        end else begin
            db_prev  <= db_state;
            pending  <= (pending & ~gmask) | edges;
            pend_dir <= (pend_dir & ~edges) | (db_state & edges);
            overflow <= ovf_set | (overflow & ~clear_overflow);
            if (grant_valid)
                last_grant <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++)
                mem[k] <= '0;
        end else begin
            if (grant_valid) begin
                mem[wptr[AW-1:0]] <= {grant, pend_dir[grant]};
                wptr              <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    assign head      = mem[rptr[AW-1:0]];
    assign evt_id    = head[ID_W:1];
    assign evt_press = head[0] == EVT_PRESS;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: randomized bench against a cycle-level behavioural model.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] buttons;
    logic [N-1:0] db_state;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic         evt_press;
    logic         overflow;
    logic         clear_overflow;

    always #5 clk = ~clk;

    button_event_ctrl #(.NUM_BTN(N), .TICK_DIV(TD), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .buttons        (buttons),
        .db_state       (db_state),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_id         (evt_id),
        .evt_press      (evt_press),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int n_chk = 0;
    int n_err = 0;
    int ev_seen = 0;
    bit ovf_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: debounce as run length of identical samples, FIFO as a queue.
    int m_cnt;
    int m_run [N];
    bit m_last[N];
    bit m_db  [N];
    bit m_prev[N];
    bit m_pend[N];
    bit m_dir [N];
    int m_lg;
    bit m_ovf;
    int q[$];

    task automatic model_step(input bit rst, input bit en, input bit rdy, input bit clr,
                              input bit [N-1:0] b);
        bit tick;
        bit set_ovf;
        int g;
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 8; m_last[i] = 0; m_db[i] = 0;
                m_prev[i] = 0; m_pend[i] = 0; m_dir[i] = 0;
            end
            m_lg = N - 1;
            m_ovf = 0;
            q.delete();
            return;
        end
        tick = en && (m_cnt == TD - 1);
        if (en) m_cnt = (m_cnt + 1) % TD;
        g = -1;
        if (q.size() < D)
            for (int k = 1; k <= N; k++)
                if (g < 0 && m_pend[(m_lg + k) % N]) g = (m_lg + k) % N;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(g * 2 + int'(m_dir[g]));
            m_lg = g;
            m_pend[g] = 0;
        end
        set_ovf = 0;
        for (int i = 0; i < N; i++) begin
            if (m_db[i] != m_prev[i]) begin
                if (m_pend[i]) set_ovf = 1;
                m_pend[i] = 1;
                m_dir[i] = m_db[i];
            end
            m_prev[i] = m_db[i];
            if (tick) begin
                if (b[i] == m_last[i]) m_run[i]++;
                else begin m_last[i] = b[i]; m_run[i] = 1; end
                if (m_run[i] >= 8) m_db[i] = m_last[i];
            end
        end
        m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic cyc(input bit [N-1:0] b, input bit en, input bit rdy, input bit clr,
                       input bit rst);
        bit [N-1:0] exp_db;
        buttons = b; enable = en; evt_ready = rdy; clear_overflow = clr; reset = rst;
        if (!rst && rdy && evt_valid) ev_seen++;
        @(posedge clk);
        model_step(rst, en, rdy, clr, b);
        #1;
        for (int i = 0; i < N; i++) exp_db[i] = m_db[i];
        check("db_state", 32'(db_state), 32'(exp_db));
        check("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("evt_id", 32'(evt_id), q[0] / 2);
            check("evt_press", 32'(evt_press), q[0] % 2);
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (overflow) ovf_seen = 1;
    endtask

    initial begin
        bit [N-1:0] cur;
        int blk;
        bit rdy;
        evt_valid_init: begin
            buttons = '0; enable = 1; evt_ready = 0; clear_overflow = 0; reset = 1;
        end
        repeat (3) cyc('0, 1, 0, 0, 1);
        check("reset_evt_id", 32'(evt_id), 0);
        check("reset_evt_press", 32'(evt_press), 0);
        // single press and release on button 2
        repeat (40) cyc(4'b0100, 1, 0, 0, 0);
        repeat (4) cyc(4'b0100, 1, 1, 0, 0);
        repeat (40) cyc(4'b0000, 1, 1, 0, 0);
        // round robin: grant button 1 first, then 0 and 3 together
        repeat (40) cyc(4'b0010, 1, 1, 0, 0);
        repeat (40) cyc(4'b1011, 1, 1, 0, 0);
        // enable low: steady press never debounces
        repeat (60) cyc(4'b1111, 0, 1, 0, 0);
        repeat (40) cyc(4'b0000, 1, 1, 0, 0);
        cur = '0;
        for (int c = 0; c < 4000; c++) begin
            blk = c / 150;
            rdy = (blk % 3 == 0) ? 1'b1 : (blk % 3 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 49) == 0) cur[i] = ~cur[i];
            if (blk % 5 == 3 && $urandom_range(0, 2) == 0) cur[1] = ~cur[1];
            cyc(cur, blk % 7 != 5, rdy, $urandom_range(0, 99) == 0, c == 2600);
        end
        check("events_seen", 32'(ev_seen > 20), 1);
        check("overflow_seen", 32'(ovf_seen), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
